sloth_square_scheduler: RTL and testbench

- Sequential round-robin scheduler for the 64-square arbitration datapath.
- Latches a 64-bit square request mask, then grants each requesting square index (0..63) one at a time to a downstream consumer using a valid/ready handshake.
- Fairness rotates across scans: each new scan begins just after the last square granted in the previous scan.
- Sits between the board-state/move-candidate logic and the shared 6-bit square/move evaluation path.

---
 rtl/sloth_square_scheduler.sv | 112 +++++++++++
 tb/tb_sloth_square_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sloth_square_scheduler.sv
// Round-robin scheduler: latches a 64-square request mask and grants each requesting
// square one at a time over a valid/ready handshake, rotating the start point across scans.
module sloth_square_scheduler #(
    parameter int NSQ  = 64,
    parameter int IDXW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [NSQ-1:0]  req_mask,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    input  logic            grant_ready,
    output logic            busy,
    output logic            done,
    output logic [IDXW:0]   grant_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OFFER,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSQ-1:0]  pending;
    logic [IDXW-1:0] rr_ptr;

    logic [NSQ-1:0]  upper_pending;
    logic            hit_upper;
    logic            hit_any;
    logic [IDXW-1:0] idx_upper;
    logic [IDXW-1:0] idx_any;
    logic [IDXW-1:0] found_idx;
    logic            handshake;

    // Returns {found, index of lowest set bit}; scanning downward lets the lowest hit win.
    function automatic logic [IDXW:0] find_lowest(input logic [NSQ-1:0] vec);
        logic [IDXW:0] res;
        res = '0;
        for (int i = NSQ - 1; i >= 0; i--) begin
            if (vec[i]) res = {1'b1, IDXW'(i)};
        end
        return res;
    endfunction

    // Requests at or above the rotation pointer take precedence; otherwise wrap to the bottom.
    assign upper_pending          = pending & ({NSQ{1'b1}} << rr_ptr);
    assign {hit_upper, idx_upper} = find_lowest(upper_pending);
    assign {hit_any, idx_any}     = find_lowest(pending);
    assign found_idx              = hit_upper ? idx_upper : idx_any;

    // Outputs decode the state register only, so no input reaches them combinationally.
    assign grant_valid = (state == OFFER);
    assign busy        = (state == SCAN) || (state == OFFER);
    assign done        = (state == DONE);
    assign handshake   = grant_valid & grant_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    state_nxt = hit_any ? OFFER : DONE;
            OFFER:   if (handshake) state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_count <= '0;
        end else if (abort) begin
            // NOTE: non-blocking assignments keep every register update tied to the same edge.
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending     <= req_mask;
                        grant_count <= '0;
                    end
                end
                SCAN: begin
                    if (hit_any) grant_idx <= found_idx;
                end
                OFFER: begin
                    if (grant_ready) begin
                        pending[grant_idx] <= 1'b0;
                        grant_count        <= grant_count + (IDXW + 1)'(1);
                        rr_ptr             <= grant_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sloth_square_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every cycle
// against a transaction-level model that predicts the grant order from the latched mask.
module tb_sloth_square_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] req_mask = '0;
    logic        grant_valid;
    logic [5:0]  grant_idx;
    logic        grant_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [6:0]  grant_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sloth_square_scheduler #(.NSQ(64), .IDXW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .req_mask(req_mask),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_ready(grant_ready),
        .busy(busy), .done(done), .grant_count(grant_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: on an accepted start the whole grant order is known up front -- the set mask
    // bits visited in rotational order starting at the pointer left by the previous scan.
    // Each grant costs one search cycle followed by an offer held until ready.
    bit         m_busy, m_valid, m_done;
    logic [5:0] m_idx, m_rr;
    logic [6:0] m_count;
    int         m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_done = 0;
            m_idx = '0; m_rr = '0; m_count = '0;
            m_q.delete();
        end else if (abort) begin
            m_busy = 0; m_valid = 0; m_done = 0;
            m_q.delete();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (start) begin
                for (int k = 0; k < 64; k++) begin
                    int sq;
                    sq = (int'(m_rr) + k) % 64;
                    if (req_mask[sq]) m_q.push_back(sq);
                end
                m_count = '0;
                m_busy  = 1;
            end
        end else if (!m_valid) begin
            if (m_q.size() == 0) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_valid = 1;
                m_idx   = 6'(m_q[0]);
            end
        end else if (grant_ready) begin
            void'(m_q.pop_front());
            m_rr    = m_idx + 6'd1;
            m_count = m_count + 7'd1;
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        check("grant_valid", 64'(grant_valid), 64'(m_valid));
        check("grant_idx", 64'(grant_idx), 64'(m_idx));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("grant_count", 64'(grant_count), 64'(m_count));
    end

    // Log of completed handshakes for the literal order checks.
    int log_idx[$];
    int log_cyc[$];
    always @(negedge clk) begin
        if (rst_n && grant_valid && grant_ready && !abort) begin
            log_idx.push_back(int'(grant_idx));
            log_cyc.push_back(cyc);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [63:0] mask);
        req_mask = mask;
        start    = 1'b1;
        next_cycle();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = done;
            #1;
        end
        if (!seen) check({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = grant_valid;
            #1;
        end
        if (!seen) check({name, "_valid_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_log(input string name, input int n, input int a, input int b, input int c);
        int e[3];
        e[0] = a; e[1] = b; e[2] = c;
        check({name, "_len"}, 64'(log_idx.size()), 64'(n));
        for (int i = 0; i < n && i < log_idx.size(); i++)
            check({name, "_order"}, 64'(log_idx[i]), 64'(e[i]));
        log_idx.delete();
        log_cyc.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 64'(grant_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(grant_count), 64'd0);
        rst_n = 1'b1;
        next_cycle();

        // Basic: bits 0 and 7 from pointer 0.
        grant_ready = 1'b1;
        pulse_start(64'h0000_0000_0000_0081);
        wait_done("basic", 50);
        check("basic_count", 64'(grant_count), 64'd2);
        check_log("basic", 2, 0, 7, 0);
        next_cycle();
        check("basic_busy_after", 64'(busy), 64'd0);

        // Rotation from pointer 8 with wrap through 63.
        pulse_start(64'h8000_0000_0000_0108);
        wait_done("wrap", 50);
        check("wrap_count", 64'(grant_count), 64'd3);
        check_log("wrap", 3, 8, 63, 3);
        next_cycle();

        // Backpressure on a single request.
        grant_ready = 1'b0;
        pulse_start(64'h0000_0000_0000_0020);
        repeat (11) next_cycle();
        check("bp_valid_held", 64'(grant_valid), 64'd1);
        check("bp_idx_held", 64'(grant_idx), 64'd5);
        grant_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("bp_done_next_but_one", 64'(done), 64'd1);
        #1;
        check_log("bp", 1, 5, 0, 0);
        next_cycle();

        // Empty mask: done two cycles after start, no grants.
        pulse_start(64'h0);
        @(posedge clk); #1;
        check("empty_done_n2", 64'(done), 64'd1);
        #1;
        check("empty_count", 64'(grant_count), 64'd0);
        check_log("empty", 0, 0, 0, 0);
        next_cycle();

        // Start during an offer is ignored; pointer is 6 so order is 1 then 2.
        grant_ready = 1'b0;
        pulse_start(64'h0000_0000_0000_0006);
        wait_valid("ign", 20);
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF);
        grant_ready = 1'b1;
        wait_done("ign", 50);
        check("ign_count", 64'(grant_count), 64'd2);
        check_log("ign", 2, 1, 2, 0);
        next_cycle();

        // Grant 63 to bring the pointer back to 0, then all 64 requests.
        pulse_start(64'h8000_0000_0000_0000);
        wait_done("to_zero", 20);
        check_log("to_zero", 1, 63, 0, 0);
        next_cycle();
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("all", 400);
        check("all_count", 64'(grant_count), 64'd64);
        check("all_len", 64'(log_idx.size()), 64'd64);
        for (int i = 0; i < 64 && i < log_idx.size(); i++) begin
            check("all_order", 64'(log_idx[i]), 64'(i));
            if (i > 0) check("all_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'd2);
        end
        log_idx.delete();
        log_cyc.delete();
        next_cycle();

        // Abort during an offer with ready high: handshake not counted, no done.
        pulse_start(64'h0000_0000_0010_0400);
        wait_valid("abort", 20);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check("abort_valid", 64'(grant_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_count", 64'(grant_count), 64'd0);
        check_log("abort", 0, 0, 0, 0);
        repeat (3) next_cycle();

        // Move pointer to 5, then reset mid-scan; the next scan must start from 0 again.
        pulse_start(64'h0000_0000_0000_0010);
        wait_done("pre_rst", 20);
        check_log("pre_rst", 1, 4, 0, 0);
        next_cycle();
        pulse_start(64'h8000_0000_0000_0108);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(grant_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_idx", 64'(grant_idx), 64'd0);
        check("rst_mid_count", 64'(grant_count), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        pulse_start(64'h8000_0000_0000_0108);
        wait_done("post_rst", 50);
        check_log("post_rst", 3, 3, 8, 63);
        next_cycle();

        // Randomized traffic: starts, masks, backpressure and rare aborts.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 4)
                0:       req_mask = {$urandom, $urandom};
                1:       req_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2:       req_mask = 64'd1 << ($urandom % 64);
                default: req_mask = '0;
            endcase
            start       = ($urandom % 6) == 0;
            grant_ready = ($urandom % 4) != 0;
            abort       = ($urandom % 80) == 0;
            next_cycle();
        end
        start       = 1'b0;
        abort       = 1'b0;
        grant_ready = 1'b1;
        repeat (200) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
